pipelined_datapath: RTL and testbench

PIPELINED_DATAPATH -- requirements
Module: pipelined_datapath

---
 rtl/pipelined_datapath.sv | 210 +++++++++++++++++++++
 tb/tb_pipelined_datapath.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_datapath.sv
// -----------------------------------------------------------------------------
// pipelined_datapath
//
// Two-stage register-file datapath: EX (operand read, ALU, result select) and
// WB (register file write). One instruction per cycle is accepted whenever
// issue_valid is high. A result is written into the register file one cycle
// after issue, and that pending result is forwarded to readers in the
// meantime.
//
// Parameters
//   DATA_W  operand / result / register width in bits (4..32)
//   NREG    number of registers, power of two (2..64)
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst_n            synchronous active-low reset
//   issue_valid      an instruction is presented this cycle
//   alu_en           1: write the ALU result, 0: write user_write_data
//   alu_opcode       ALU operation select
//   user_write_data  external write value used when alu_en=0
//   write_addr       destination register
//   ra_addr/rb_addr  source register addresses
//   write_en         the instruction writes write_addr
//   read_a/read_b    forwarded operand values (combinational)
//   wb_valid         WB stage holds a pending register write
//   wb_addr/wb_data  pending writeback address and data
//   zero_flag        registered ALU zero flag
//   carry_flag       registered ALU carry / borrow flag
// -----------------------------------------------------------------------------
module pipelined_datapath #(
  parameter int DATA_W = 8,
  parameter int NREG   = 16,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              alu_en,
  input  logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] user_write_data,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              write_en,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              carry_flag
);

  // ---------------------------------------------------------------------------
  // ALU operation encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_PASS = 4'd8,
    OP_INC  = 4'd9,
    OP_DEC  = 4'd10
  } alu_op_e;

  localparam logic [DATA_W:0] ONE_W = {{DATA_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic              wb_valid_q,   wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q,    wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,    wb_data_d;
  logic              zero_flag_q,  zero_flag_d;
  logic              carry_flag_q, carry_flag_d;

  // ---------------------------------------------------------------------------
  // Operand read with forwarding from the WB stage. Only the already-registered
  // WB result is bypassed; the instruction currently in EX is never visible
  // here, so there is no combinational path from write inputs to read_a/b.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  always_comb begin
    op_a = regs_q[ra_addr];
    op_b = regs_q[rb_addr];
    if (wb_valid_q && (wb_addr_q == ra_addr)) op_a = wb_data_q;
    if (wb_valid_q && (wb_addr_q == rb_addr)) op_b = wb_data_q;
  end

  assign read_a = op_a;
  assign read_b = op_b;

  // ---------------------------------------------------------------------------
  // ALU. Arithmetic is done one bit wider so the extra MSB directly gives the
  // carry-out (ADD/INC) or borrow (SUB/DEC: the wrap below zero sets it).
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              alu_zero;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    alu_wide  = '0;
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        alu_wide  = {1'b0, op_a} + {1'b0, op_b};
        alu_out   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      OP_SUB: begin
        alu_wide  = {1'b0, op_a} - {1'b0, op_b};
        alu_out   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_NOT:  alu_out = ~op_a;
      OP_SHL: begin
        alu_out   = {op_a[DATA_W-2:0], 1'b0};
        alu_carry = op_a[DATA_W-1];
      end
      OP_SHR: begin
        alu_out   = {1'b0, op_a[DATA_W-1:1]};
        alu_carry = op_a[0];
      end
      OP_PASS: alu_out = op_b;
      OP_INC: begin
        alu_wide  = {1'b0, op_a} + ONE_W;
        alu_out   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      OP_DEC: begin
        alu_wide  = {1'b0, op_a} - ONE_W;
        alu_out   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      default: begin
        alu_out   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  assign alu_zero = (alu_out == '0);

  // ---------------------------------------------------------------------------
  // Next-state: EX -> WB register, flags, register file write
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_valid_d   = issue_valid & write_en;
    wb_addr_d    = write_addr;
    wb_data_d    = alu_en ? alu_out : user_write_data;

    // Flags track only ALU instructions; plain data loads leave them alone.
    zero_flag_d  = zero_flag_q;
    carry_flag_d = carry_flag_q;
    if (issue_valid && alu_en) begin
      zero_flag_d  = alu_zero;
      carry_flag_d = alu_carry;
    end

    regs_d = regs_q;
    if (wb_valid_q) regs_d[wb_addr_q] = wb_data_q;
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      zero_flag_q  <= 1'b0;
      carry_flag_q <= 1'b0;
      // NOTE: the register file is cleared on reset because software relies
      // on reading zero from never-written registers; this keeps it in flops
      // rather than a RAM macro, which is acceptable at these sizes.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      zero_flag_q  <= zero_flag_d;
      carry_flag_q <= carry_flag_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign zero_flag  = zero_flag_q;
  assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_pipelined_datapath.sv
// -----------------------------------------------------------------------------
// tb_pipelined_datapath
//
// Directed test of pipelined_datapath at DATA_W=8, NREG=16. Inputs change
// 1 time unit after a rising edge; outputs are compared at that same point,
// i.e. well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_pipelined_datapath;

  localparam int DATA_W = 8;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              issue_valid;
  logic              alu_en;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] user_write_data;
  logic [ADDR_W-1:0] write_addr;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic              write_en;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              zero_flag;
  logic              carry_flag;

  int vectors;
  int miscompares;

  pipelined_datapath #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .alu_en          (alu_en),
    .alu_opcode      (alu_opcode),
    .user_write_data (user_write_data),
    .write_addr      (write_addr),
    .ra_addr         (ra_addr),
    .rb_addr         (rb_addr),
    .write_en        (write_en),
    .read_a          (read_a),
    .read_b          (read_b),
    .wb_valid        (wb_valid),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .zero_flag       (zero_flag),
    .carry_flag      (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction on the inputs (takes effect at the next edge).
  task automatic drive(input logic iv, input logic we, input logic ae,
                       input logic [3:0] op, input logic [7:0] ud,
                       input logic [3:0] wa, input logic [3:0] ra,
                       input logic [3:0] rb);
    issue_valid     = iv;
    write_en        = we;
    alu_en          = ae;
    alu_opcode      = op;
    user_write_data = ud;
    write_addr      = wa;
    ra_addr         = ra;
    rb_addr         = rb;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, ra_addr, rb_addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    // An instruction presented during reset must be discarded.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h55, 4'd0, 4'd0, 4'd0);
    step();
    step();
    rst_n = 1'b1;
    idle();
    #1;
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wb_valid: got %b want 0", wb_valid);
    end
    vectors++;
    if ({zero_flag, carry_flag} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_flags: got z=%b c=%b want 0 0", zero_flag, carry_flag);
    end
    for (int i = 0; i < NREG; i++) begin
      ra_addr = 4'(i);
      rb_addr = 4'(NREG - 1 - i);
      #1;
      vectors++;
      if (read_a !== 8'h00 || read_b !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_read r%0d: got a=%h b=%h want 00 00", i, read_a, read_b);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_add_carry();
    // Load R1=0xFF as a data write.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'hFF, 4'd1, 4'd0, 4'd0);
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_addr !== 4'd1 || wb_data !== 8'hFF) begin
      miscompares++;
      $display("FAIL load_r1: got v=%b a=%0d d=%h want 1 1 ff", wb_valid, wb_addr, wb_data);
    end
    // ADD R2 = R1 + R1, both operands forwarded from WB.
    drive(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 4'd2, 4'd1, 4'd1);
    #1;
    vectors++;
    if (read_a !== 8'hFF || read_b !== 8'hFF) begin
      miscompares++;
      $display("FAIL add_fwd: got a=%h b=%h want ff ff", read_a, read_b);
    end
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_addr !== 4'd2 || wb_data !== 8'hFE ||
        carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL add_ff_ff: got v=%b a=%0d d=%h c=%b z=%b want 1 2 fe 1 0",
               wb_valid, wb_addr, wb_data, carry_flag, zero_flag);
    end
    idle();
    step();
    ra_addr = 4'd1;
    rb_addr = 4'd2;
    #1;
    vectors++;
    if (wb_valid !== 1'b0 || read_a !== 8'hFF || read_b !== 8'hFE) begin
      miscompares++;
      $display("FAIL add_regfile: got v=%b a=%h b=%h want 0 ff fe", wb_valid, read_a, read_b);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sub_dec();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h05, 4'd3, 4'd0, 4'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h05, 4'd4, 4'd0, 4'd0);
    step();
    // SUB R5 = R3 - R4 (R3 from file, R4 forwarded).
    drive(1'b1, 1'b1, 1'b1, 4'd1, 8'h00, 4'd5, 4'd3, 4'd4);
    step();
    vectors++;
    if (wb_data !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_5_5: got d=%h z=%b c=%b want 00 1 0", wb_data, zero_flag, carry_flag);
    end
    // DEC R6 = R5 - 1, R5 forwarded as 0 -> borrow.
    drive(1'b1, 1'b1, 1'b1, 4'd10, 8'h00, 4'd6, 4'd5, 4'd0);
    step();
    vectors++;
    if (wb_addr !== 4'd6 || wb_data !== 8'hFF || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL dec_zero: got a=%0d d=%h c=%b z=%b want 6 ff 1 0",
               wb_addr, wb_data, carry_flag, zero_flag);
    end
    idle();
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h11, 4'd7, 4'd0, 4'd0);
    step();
    // Second write to R7; meanwhile a read of R7 sees the earlier value.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h22, 4'd7, 4'd7, 4'd7);
    #1;
    vectors++;
    if (read_a !== 8'h11) begin
      miscompares++;
      $display("FAIL b2b_dep_read: got %h want 11", read_a);
    end
    step();
    idle();
    ra_addr = 4'd7;
    #1;
    vectors++;
    if (wb_valid !== 1'b1 || read_a !== 8'h22) begin
      miscompares++;
      $display("FAIL b2b_forward: got v=%b a=%h want 1 22", wb_valid, read_a);
    end
    step();
    vectors++;
    if (wb_valid !== 1'b0 || read_a !== 8'h22) begin
      miscompares++;
      $display("FAIL b2b_regfile: got v=%b a=%h want 0 22", wb_valid, read_a);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_drop();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'hAA, 4'd8, 4'd0, 4'd0);
    step();
    // WB holds R8=0xAA; reset during this cycle must drop it.
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    ra_addr = 4'd8;
    rb_addr = 4'd7;
    #1;
    vectors++;
    if (wb_valid !== 1'b0 || read_a !== 8'h00 || read_b !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_drop: got v=%b r8=%h r7=%h want 0 00 00", wb_valid, read_a, read_b);
    end
    step();
    vectors++;
    if (read_a !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_drop_late: got r8=%h want 00", read_a);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_no_write();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h0F, 4'd9, 4'd0, 4'd0);
    step();
    idle();
    step();
    // XOR R9^R9 with write_en=0: flags update, nothing written.
    drive(1'b1, 1'b0, 1'b1, 4'd4, 8'h00, 4'd10, 4'd9, 4'd9);
    step();
    vectors++;
    if (wb_valid !== 1'b0 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL xor_nowrite: got v=%b z=%b c=%b want 0 1 0", wb_valid, zero_flag, carry_flag);
    end
    idle();
    step();
    ra_addr = 4'd10;
    rb_addr = 4'd9;
    #1;
    vectors++;
    if (read_a !== 8'h00 || read_b !== 8'h0F) begin
      miscompares++;
      $display("FAIL xor_nowrite_regs: got r10=%h r9=%h want 00 0f", read_a, read_b);
    end
  endtask

  // ---------------------------------------------------------------------------
  // All opcodes with A=R11=0x81, B=R12=0x0F.
  task automatic test_opcodes();
    logic [3:0] ops  [13];
    logic [7:0] res  [13];
    logic       cy   [13];
    logic [3:0] ras  [13];
    logic [3:0] rbs  [13];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd1};
    res = '{8'h90, 8'h72, 8'h01, 8'h8F, 8'h8E, 8'h7E, 8'h02, 8'h40, 8'h0F, 8'h82, 8'h80, 8'h00, 8'h8E};
    cy  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ras = '{4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd12};
    rbs = '{4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd11};
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h81, 4'd11, 4'd0, 4'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h0F, 4'd12, 4'd0, 4'd0);
    step();
    idle();
    step();
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b1, 1'b1, ops[i], 8'h00, 4'd13, ras[i], rbs[i]);
      step();
      vectors++;
      if (wb_valid !== 1'b1 || wb_data !== res[i] || carry_flag !== cy[i] ||
          zero_flag !== (res[i] == 8'h00)) begin
        miscompares++;
        $display("FAIL op%0d_case%0d: got v=%b d=%h c=%b z=%b want 1 %h %b %b",
                 ops[i], i, wb_valid, wb_data, carry_flag, zero_flag,
                 res[i], cy[i], (res[i] == 8'h00));
      end
    end
    // Last op left z=0 c=1. A data write must not touch the flags.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 4'd14, 4'd0, 4'd0);
    step();
    vectors++;
    if (wb_data !== 8'h00 || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL flags_hold_data: got d=%h c=%b z=%b want 00 1 0", wb_data, carry_flag, zero_flag);
    end
    // issue_valid=0 is a bubble even with write_en/alu_en set.
    drive(1'b0, 1'b1, 1'b1, 4'd12, 8'h00, 4'd15, 4'd11, 4'd12);
    step();
    vectors++;
    if (wb_valid !== 1'b0 || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble: got v=%b c=%b z=%b want 0 1 0", wb_valid, carry_flag, zero_flag);
    end
    idle();
    ra_addr = 4'd15;
    rb_addr = 4'd13;
    #1;
    vectors++;
    if (read_a !== 8'h00 || read_b !== 8'h8E) begin
      miscompares++;
      $display("FAIL bubble_regs: got r15=%h r13=%h want 00 8e", read_a, read_b);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 4'd0);
    #1;
    test_reset();
    test_add_carry();
    test_sub_dec();
    test_back_to_back();
    test_reset_drop();
    test_no_write();
    test_opcodes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
